// File: rtl/pc_reg_pkg.sv
// Shared core constants and types for the RV32I fetch-stage program counter.
package pc_reg_pkg;

    localparam int unsigned CORE_XLEN           = 32;
    localparam logic [31:0] CORE_RESET_VECTOR   = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES         = 4;

    typedef logic [CORE_XLEN-1:0] addr_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: synchronous active-low reset, load-enable stall,
// combinational sequential successor and alignment flag.
module pc_reg
    import pc_reg_pkg::*;
#(
    parameter int unsigned      XLEN         = CORE_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(CORE_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
        end else if (en) begin
            pc <= next_pc;
        end
    end

    // Wraps modulo 2^XLEN; bits [1:0] of next_pc are never masked.
    assign pc_plus4   = pc + XLEN'(INSTR_BYTES);
    assign misaligned = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_reg.sv
// Directed self-checking bench for pc_reg with hand-computed expectations.
module tb_pc_reg;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int unsigned n_asserts;
    int unsigned n_failures;

    pc_reg #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .next_pc    (next_pc),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_p4, input logic e_mis);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".pc_plus4"}, pc_plus4, e_p4);
        check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_asserts  = 0;
        n_failures = 0;

        // Reset overrides en/next_pc.
        reset = 1'b0; en = 1'b1; next_pc = 32'hDEAD_BEEF;
        step();
        check_all("reset", 32'h0, 32'h4, 1'b0);

        // Sequential loads.
        reset = 1'b1; next_pc = 32'd4;
        step();
        check_all("seq4", 32'd4, 32'd8, 1'b0);
        next_pc = 32'd8;
        step();
        check_all("seq8", 32'd8, 32'd12, 1'b0);
        next_pc = 32'd12;
        step();
        check_all("seq12", 32'd12, 32'd16, 1'b0);

        // Back to 8, then stall for three edges.
        next_pc = 32'd8;
        step();
        check("back8", pc, 32'd8);
        en = 1'b0; next_pc = 32'd12;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d", i), pc, 32'd8);
        end
        en = 1'b1;
        step();
        check_all("unstall", 32'd12, 32'd16, 1'b0);

        // Branch and wrap.
        next_pc = 32'h0000_0100;
        step();
        check_all("branch", 32'h100, 32'h104, 1'b0);
        next_pc = 32'hFFFF_FFFC;
        step();
        check_all("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

        // Misalignment is reported but does not block the load.
        next_pc = 32'h0000_0102;
        step();
        check_all("misal", 32'h102, 32'h106, 1'b1);
        next_pc = 32'h0000_0104;
        step();
        check_all("realign", 32'h104, 32'h108, 1'b0);

        // Self-loop load.
        step();
        check("selfloop", pc, 32'h104);

        // Mid-run reset with en=0.
        reset = 1'b0; en = 1'b0; next_pc = 32'h0000_0300;
        step();
        check_all("midreset", 32'h0, 32'h4, 1'b0);

        // First enabled edge after release loads next_pc.
        reset = 1'b1; en = 1'b1; next_pc = 32'h0000_0200;
        step();
        check("release", pc, 32'h200);

        // Reset pulse between edges must not affect pc.
        en = 1'b0;
        #1 reset = 1'b0;
        #2 check("pulse_mid", pc, 32'h200);
        reset = 1'b1;
        step();
        check_all("pulse_after", 32'h200, 32'h204, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule
